edge_frame_sequencer: RTL
=========================

Name: edge_frame_sequencer

Overview:
Frame-level controller for the edge-detection pipeline (grayscale, Gaussian, Sobel, Canny).
- On a start pulse it reads one H_RES x V_RES RGB frame from a synchronous-read frame buffer.
- It generates the vsync/hsync/de timing the pipeline's line buffers need, including horizontal blanking and trailing flush lines.
- It counts the pixels the pipeline emits and reports done, or error on timeout.

Parameters:
WIDTH, 8, bits per colour channel
H_RES, 170, active pixels per line
V_RES, 240, active lines per frame
H_BLANK, 16, blanking cycles after each line (must be greater than or equal to HS_CYC, and at least 1)
HS_CYC, 4, hsync high cycles at start of each blanking period
VS_CYC, 8, vsync high cycles before first line
FLUSH_LINES, 4, extra de-low lines (with hsync) appended to drain line buffers
TIMEOUT, 4096, cycles allowed after flush for output count to complete
ADDR_W, 16, frame-buffer address width (H_RES*V_RES must be at most 2^ADDR_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse; starts a frame when idle, ignored when busy
i_abort  in  1  returns to IDLE next cycle and drops all outputs low; no done pulse
o_busy  out  1  high from the cycle after an accepted start until the cycle done or err is asserted
o_done  out  1  one-cycle pulse: frame finished and output count equals H_RES*V_RES
o_err  out  1  one-cycle pulse: timeout expired with output count short
o_rd_en  out  1  frame-buffer read enable
o_rd_addr  out  ADDR_W  linear pixel address, row-major, starting at 0
i_rd_r/i_rd_g/i_rd_b  in  WIDTH each  read data, valid exactly 1 cycle after o_rd_en
o_vsync, o_hsync, o_de  out  1 each  timing to pipeline input
o_r_data/o_g_data/o_b_data  out  WIDTH each  pixel to pipeline, equal to read data, aligned with o_de
i_pipe_de  in  1  de from pipeline output
o_pix_cnt  out  ADDR_W+1  pipeline output pixels counted this frame

Behaviour:
- Reset (rst=1 at a clock edge) drives every output to 0, state to IDLE and all counters to 0. The same applies on i_abort.
- States: IDLE → VSYNC → ACTIVE ⇄ HBLANK → FLUSH → DRAIN → IDLE.
- IDLE:
  - i_start=1 → VSYNC, o_busy=1, o_pix_cnt cleared to 0.
  - i_start and i_abort high together: abort wins, remain IDLE.
- VSYNC:
  - internal vsync high for VS_CYC cycles, then → ACTIVE with line=0, col=0.
- ACTIVE:
  - o_rd_en=1, o_rd_addr=line*H_RES+col; the address increments by 1 per cycle.
  - After col=H_RES-1 → HBLANK.
- HBLANK:
  - H_BLANK cycles; internal hsync high for the first HS_CYC of them.
  - Then → ACTIVE if line<V_RES-1 (line+1), else → FLUSH.
- FLUSH:
  - FLUSH_LINES pseudo-lines, each H_RES de-low cycles followed by an H_BLANK period with hsync as in HBLANK.
  - o_rd_en=0. Then → DRAIN.
- DRAIN:
  - Wait with the timeout counter running.
  - If o_pix_cnt=H_RES*V_RES → o_done pulse, → IDLE.
  - Else if the counter reaches TIMEOUT → o_err pulse, → IDLE.
  - If both conditions hit in the same cycle, done wins.
- Alignment:
  - o_vsync/o_hsync/o_de are the internal decodes registered once, so they are 1 cycle behind o_rd_en/o_rd_addr.
  - RGB outputs are registered from i_rd_* in the same cycle that o_de is high. Outside that cycle RGB outputs are 0.
- Latency: with start sampled at cycle 0, VSYNC spans cycles 1..VS_CYC, the first o_rd_en is at cycle VS_CYC+1, and the first o_de is at VS_CYC+2.
- o_pix_cnt:
  - Increments on every i_pipe_de=1 while busy.
  - Saturates at all-ones. Pixels beyond H_RES*V_RES are still counted and produce o_err at DRAIN timeout rather than done; o_done requires an exact count.
  - Holds its value after the frame ends; cleared on the next accepted start.
- o_busy falls in the same cycle that o_done/o_err is asserted.
- i_start while busy is ignored; no queueing.

Decomposition:
- Package edge_seq_pkg:
  - state enum: IDLE, VSYNC, ACTIVE, HBLANK, FLUSH, DRAIN.
  - function computing FRAME_PIXELS = H_RES*V_RES.
- One sub-module, edge_seq_timing: col/line/blank counters and sync decode, driven by the state.
- The top holds the FSM, read-address generation, the alignment registers, the pixel counter and the timeout.

Test Plan:
1. Reset: hold rst 3 cycles mid-ACTIVE → next cycle all outputs 0, state IDLE; a following start runs a clean frame.
2. Nominal frame, H_RES=4, V_RES=3, H_BLANK=2, HS_CYC=1, VS_CYC=2, FLUSH_LINES=1, frame buffer content = address:
   - addresses 0..11 issued in 3 bursts of 4;
   - o_de has 12 high cycles, each with data equal to the previous cycle's address;
   - first o_de at cycle 4;
   - a pipeline model echoing 12 de pulses → o_done once, o_pix_cnt=12.
3. Timeout: pipeline returns only 11 pixels → o_err pulses exactly TIMEOUT cycles after DRAIN entry, o_done never asserts, o_pix_cnt=11.
4. Abort: i_abort during the second line → next cycle o_rd_en/o_de/o_busy=0 and no done/err; a restart then reads from address 0.
5. Start while busy: extra i_start pulses in ACTIVE and DRAIN → ignored; exactly one frame and one done.
6. Edge of done/timeout: the 12th pipeline pixel arrives on the TIMEOUT cycle → o_done=1, o_err=0.

Source files
------------

// File: rtl/edge_frame_sequencer_pkg.sv
// edge_seq_pkg: state encoding and frame-size helper shared by the edge frame sequencer
package edge_seq_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, ACTIVE, HBLANK, FLUSH, DRAIN} state_e;
  function automatic int frame_pixels(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction
endpackage

// File: rtl/edge_frame_sequencer_if.sv
// edge_frame_sequencer_if: frame-buffer read bus, pipeline video bus and output pixel count
interface edge_frame_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 16
);
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [WIDTH-1:0]  i_rd_r;
  logic [WIDTH-1:0]  i_rd_g;
  logic [WIDTH-1:0]  i_rd_b;
  logic              o_vsync;
  logic              o_hsync;
  logic              o_de;
  logic [WIDTH-1:0]  o_r_data;
  logic [WIDTH-1:0]  o_g_data;
  logic [WIDTH-1:0]  o_b_data;
  logic              i_pipe_de;
  logic [ADDR_W:0]   o_pix_cnt;
  modport master (
    output o_rd_en, o_rd_addr, o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_pix_cnt,
    input  i_rd_r, i_rd_g, i_rd_b, i_pipe_de
  );
  modport slave (
    input  o_rd_en, o_rd_addr, o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_pix_cnt,
    output i_rd_r, i_rd_g, i_rd_b, i_pipe_de
  );
endinterface

// File: rtl/edge_frame_sequencer_timing.sv
// edge_seq_timing: phase and line counters plus hsync decode, stepped by the sequencer state
module edge_seq_timing
  import edge_seq_pkg::*;
#(
  parameter int H_RES       = 170,
  parameter int V_RES       = 240,
  parameter int H_BLANK     = 16,
  parameter int HS_CYC      = 4,
  parameter int VS_CYC      = 8,
  parameter int FLUSH_LINES = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  state_e state_i,
  output logic   vs_end_o,
  output logic   col_end_o,
  output logic   hb_end_o,
  output logic   last_line_o,
  output logic   flush_end_o,
  output logic   hsync_o
);
  localparam int LINE_LEN = H_RES + H_BLANK;
  localparam int CNT_MAX  = LINE_LEN > VS_CYC ? LINE_LEN : VS_CYC;
  localparam int LINE_MAX = V_RES > FLUSH_LINES ? V_RES : FLUSH_LINES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int LN_W     = $clog2(LINE_MAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LN_W-1:0]  line_q, line_d;
  logic             fl_line_end;
  always_comb begin
    vs_end_o    = state_i == VSYNC && cnt_q == CNT_W'(VS_CYC - 1);
    col_end_o   = state_i == ACTIVE && cnt_q == CNT_W'(H_RES - 1);
    hb_end_o    = state_i == HBLANK && cnt_q == CNT_W'(H_BLANK - 1);
    fl_line_end = state_i == FLUSH && cnt_q == CNT_W'(LINE_LEN - 1);
    last_line_o = line_q == LN_W'(V_RES - 1);
    flush_end_o = fl_line_end && line_q == LN_W'(FLUSH_LINES - 1);
    // a flush pseudo-line is H_RES idle cycles then a normal blanking period
    hsync_o     = (state_i == HBLANK && cnt_q < CNT_W'(HS_CYC)) ||
                  (state_i == FLUSH && cnt_q >= CNT_W'(H_RES) && cnt_q < CNT_W'(H_RES + HS_CYC));
    cnt_d       = (state_i == IDLE || state_i == DRAIN || vs_end_o || col_end_o || hb_end_o || fl_line_end)
                  ? '0 : cnt_q + 1'b1;
    line_d      = state_i == IDLE ? '0 :
                  hb_end_o ? (last_line_o ? '0 : line_q + 1'b1) :
                  fl_line_end ? line_q + 1'b1 : line_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end
endmodule

// File: rtl/edge_frame_sequencer.sv
// edge_frame_sequencer: reads one frame, generates pipeline video timing, counts returned
// pixels and reports done or timeout error
module edge_frame_sequencer
  import edge_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int H_RES       = 170,
  parameter int V_RES       = 240,
  parameter int H_BLANK     = 16,
  parameter int HS_CYC      = 4,
  parameter int VS_CYC      = 8,
  parameter int FLUSH_LINES = 4,
  parameter int TIMEOUT     = 4096,
  parameter int ADDR_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_abort,
  output logic o_busy,
  output logic o_done,
  output logic o_err,
  edge_frame_sequencer_if.master bus
);
  localparam int FRAME = frame_pixels(H_RES, V_RES);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  state_e            state_q, state_d;
  logic              clr, start_acc;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              vs_end, col_end, hb_end, last_line, flush_end, hsync;
  logic              vs_q, hs_q, de_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   pix_q, pix_d;
  logic [TO_W-1:0]   to_q, to_d;
  assign clr = rst || i_abort;
  edge_seq_timing #(
    .H_RES(H_RES), .V_RES(V_RES), .H_BLANK(H_BLANK),
    .HS_CYC(HS_CYC), .VS_CYC(VS_CYC), .FLUSH_LINES(FLUSH_LINES)
  ) u_timing (
    .clk(clk),
    .rst(clr),
    .state_i(state_q),
    .vs_end_o(vs_end),
    .col_end_o(col_end),
    .hb_end_o(hb_end),
    .last_line_o(last_line),
    .flush_end_o(flush_end),
    .hsync_o(hsync)
  );
  always_comb begin
    start_acc = state_q == IDLE && i_start;
    addr_d    = start_acc ? '0 : state_q == ACTIVE ? addr_q + 1'b1 : addr_q;
    pix_d     = start_acc ? '0 : (busy_q && bus.i_pipe_de && !(&pix_q)) ? pix_q + 1'b1 : pix_q;
    to_d      = state_q == DRAIN ? to_q + 1'b1 : '0;
    state_d   = state_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE:   state_d = i_start ? VSYNC : IDLE;
      VSYNC:  state_d = vs_end ? ACTIVE : VSYNC;
      ACTIVE: state_d = col_end ? HBLANK : ACTIVE;
      HBLANK: state_d = hb_end ? (last_line ? FLUSH : ACTIVE) : HBLANK;
      FLUSH:  state_d = flush_end ? DRAIN : FLUSH;
      DRAIN: begin
        // count includes this cycle's pixel, so a last pixel on the timeout cycle still completes
        done_d  = pix_d == (ADDR_W + 1)'(FRAME);
        err_d   = !done_d && to_q == TO_W'(TIMEOUT - 1);
        state_d = (done_d || err_d) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    busy_d = start_acc || (busy_q && !done_d && !err_d);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      pix_q   <= '0;
      to_q    <= '0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      to_q    <= to_d;
      vs_q    <= state_q == VSYNC;
      hs_q    <= hsync;
      de_q    <= state_q == ACTIVE;
    end
  end
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign bus.o_rd_en   = state_q == ACTIVE;
  assign bus.o_rd_addr = addr_q;
  assign bus.o_vsync   = vs_q;
  assign bus.o_hsync   = hs_q;
  assign bus.o_de      = de_q;
  assign bus.o_pix_cnt = pix_q;
  // buffer data already lands one cycle after the read, in step with de, so it is only gated
  assign bus.o_r_data  = de_q ? bus.i_rd_r : WIDTH'(0);
  assign bus.o_g_data  = de_q ? bus.i_rd_g : WIDTH'(0);
  assign bus.o_b_data  = de_q ? bus.i_rd_b : WIDTH'(0);
endmodule
